elevator_car_ctrl: RTL
======================

Name: elevator_car_ctrl

Overview:
- Car-motion controller: the upstream end of the door-controller interface. It latches floor call requests and moves the car one floor at a time under a travel timer.
- On reaching a requested floor it issues the one-cycle `arr` pulse to the door subsystem. It then holds the car until the door subsystem returns `door_closed` (the door block's close signal), after which the next trip is scheduled.
- Scheduling is a simple SCAN policy: keep the current direction while requests lie ahead, otherwise reverse.

Parameters:
- FLOORS, 8, number of floors; floor 0 is the bottom floor.
- FLOOR_W, 3, width of the floor index; must satisfy 2**FLOOR_W >= FLOORS.
- TRAVEL_CYC, 20, clock cycles to travel between adjacent floors; legal range is >= 2.
- DOOR_TMO_CYC, 200, watchdog limit in cycles while waiting for `door_closed`; used only with DOOR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- r  in  1  reset; asynchronous, active-high.
- call_req  in  FLOORS  call buttons; one bit per floor; level or pulse; sampled every cycle.
- door_closed  in  1  door subsystem reports the door is fully closed; level.
- arr  out  1  arrival pulse to the door subsystem; high for exactly 1 cycle.
- floor  out  FLOOR_W  current car floor.
- dir_up  out  1  current direction is up.
- dir_dn  out  1  current direction is down.
- moving  out  1  car is between floors (state MOVE).
- pending  out  FLOORS  latched outstanding requests.
- door_fault  out  1  door watchdog tripped; exists only with DOOR_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, r=1): state=IDLE, floor=0, arr=0, dir_up=0, dir_dn=0, moving=0, pending=0, travel counter=0, door_fault=0.
- Request latch, every cycle: pending <= (pending | call_req) & ~clr_mask.
  - clr_mask is the one-hot of `floor` while in ARRIVE or DOOR_WAIT, and zero otherwise.
  - A clear and a new call to the same floor in the same cycle: the clear wins, so no duplicate service.
- State IDLE:
  - pending==0: stay in IDLE; dir_up=dir_dn=0.
  - pending[floor]==1: go to ARRIVE next cycle. No motion.
  - Otherwise: pick a direction (below), go to MOVE, and load the counter with 0.
- Direction choice:
  - Requests above the current floor and (dir_up or no direction held): up.
  - Else requests below: down.
  - Else requests above: up.
  - Exactly one of dir_up/dir_dn is high during MOVE.
- State MOVE: moving=1; the counter increments each cycle.
  - When the counter reaches TRAVEL_CYC-1: floor steps ±1 on that clock edge and the counter clears.
  - After the step, if pending[new floor]: go to ARRIVE.
  - Else, if requests remain ahead: stay in MOVE.
  - Else: re-run the direction choice from MOVE, reversing if needed.
  - Floor never leaves 0..FLOORS-1. A step is never issued past the end floors; the direction choice guarantees this, and an assertion checks it.
- State ARRIVE (1 cycle): arr=1 and moving=0; pending[floor] is cleared; next state is DOOR_WAIT.
- State DOOR_WAIT:
  - door_closed is ignored during the first cycle, because the door block needs a cycle to deassert it.
  - From the second cycle on, door_closed==1 moves the FSM to IDLE.
  - A call to the current floor in this state is absorbed (cleared) with no new arr.
- Latency:
  - Call at the current floor while IDLE: arr rises 2 cycles after call_req rises (1 cycle to latch, 1 cycle through IDLE).
  - Call n floors away: arr rises after 2 + n*TRAVEL_CYC cycles.
- Reset mid-trip: immediate return to reset values. The car position is lost by design and floor reads 0.

Optional Feature:
- Macro: DOOR_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts DOOR_WAIT cycles.
  - At DOOR_TMO_CYC without door_closed, the FSM returns to ARRIVE: arr re-pulses, door_fault is set and the watchdog restarts.
  - door_fault stays set until reset.
- Without the macro: DOOR_WAIT waits indefinitely; there is no door_fault port and no watchdog logic.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, MOVE, ARRIVE, DOOR_WAIT};
  - the direction enum {DIR_NONE, DIR_UP, DIR_DN};
  - the default FLOORS/FLOOR_W constants, shared with the door controller.
- One sub-module, travel_timer: a parameterised counter with clear/enable and a terminal-count flag. It is instantiated twice: once for travel, and once for the watchdog when DOOR_TIMEOUT_EN is defined.

Test Plan:
- All directed tests run with TRAVEL_CYC=4, DOOR_TMO_CYC=10 and FLOORS=8.
- Reset, then hold idle for 20 cycles -> floor=0, arr never pulses, pending=0.
- Pulse call_req[0] at floor 0 (cycle t) -> arr high at t+2 only; pending[0] clears; then a door_closed pulse -> IDLE.
- Pulse call_req[3] from floor 0 -> dir_up=1, moving=1, floor steps every 4 cycles; arr at t+14; floor=3.
- At floor 3 with dir_up, pulse calls 5 and 1 together -> service order 5 then 1; dir_dn after floor 5.
- During DOOR_WAIT at floor 5, press call_req[5] -> no extra arr and pending[5] stays 0.
- With DOOR_TIMEOUT_EN defined and door_closed held 0 -> arr re-pulses every 11 cycles; door_fault=1 from the first timeout. Then assert r mid-MOVE -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/elevator_car_ctrl_pkg.sv
// Shared types and default sizing for the elevator car controller and the door controller.
// The door watchdog inside elevator_car_ctrl is built only when DOOR_TIMEOUT_EN is defined.
package elevator_car_ctrl_pkg;

  localparam int DEF_FLOORS  = 8;
  localparam int DEF_FLOOR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    ARRIVE,
    DOOR_WAIT
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_e;

  // SCAN choice: keep going up while work lies above, otherwise serve below, otherwise above.
  function automatic dir_e choose_dir(input logic above, input logic below, input dir_e cur);
    dir_e d;
    if (above && (cur != DIR_DN)) d = DIR_UP;
    else if (below)               d = DIR_DN;
    else if (above)               d = DIR_UP;
    else                          d = DIR_NONE;
    return d;
  endfunction

endpackage

// File: rtl/elevator_car_ctrl_travel_timer.sv
// travel_timer: cycle counter with clear/enable that wraps and flags its terminal count (LIMIT-1).
module travel_timer #(
  parameter int LIMIT = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Car-motion controller: latches floor calls, moves one floor per travel period under SCAN and
// hands off to the door subsystem with a one-cycle arr pulse. DOOR_TIMEOUT_EN adds a door watchdog.
module elevator_car_ctrl
  import elevator_car_ctrl_pkg::*;
#(
  parameter int FLOORS       = DEF_FLOORS,
  parameter int FLOOR_W      = DEF_FLOOR_W,
  parameter int TRAVEL_CYC   = 20,
  parameter int DOOR_TMO_CYC = 200
) (
  input  logic               clk,
  input  logic               r,
  input  logic [FLOORS-1:0]  call_req,
  input  logic               door_closed,
  output logic               arr,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               dir_dn,
  output logic               moving,
  output logic [FLOORS-1:0]  pending
`ifdef DOOR_TIMEOUT_EN
  ,
  output logic               door_fault
`endif
);

  localparam bit PARAMS_OK = (TRAVEL_CYC >= 2) && (DOOR_TMO_CYC >= 2) && ((2 ** FLOOR_W) >= FLOORS);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic               dw_first_q;
  logic               travel_tc;

  logic [FLOOR_W-1:0] floor_nxt;
  logic [FLOORS-1:0]  floor_oh, nxt_oh, clr_mask;
  logic [FLOORS-1:0]  above_cur_v, below_cur_v, above_nxt_v, below_nxt_v;
  logic               ahead_nxt;

  assign floor_nxt = (dir_q == DIR_DN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
  assign floor_oh  = FLOORS'(1) << floor_q;
  assign nxt_oh    = FLOORS'(1) << floor_nxt;

  // Outstanding work on each side of the current floor and of the floor being stepped into.
  for (genvar gi = 0; gi < FLOORS; gi++) begin : g_req_side
    assign above_cur_v[gi] = pending_q[gi] && (FLOOR_W'(gi) > floor_q);
    assign below_cur_v[gi] = pending_q[gi] && (FLOOR_W'(gi) < floor_q);
    assign above_nxt_v[gi] = pending_q[gi] && (FLOOR_W'(gi) > floor_nxt);
    assign below_nxt_v[gi] = pending_q[gi] && (FLOOR_W'(gi) < floor_nxt);
  end

  assign ahead_nxt = (dir_q == DIR_UP) ? |above_nxt_v : |below_nxt_v;

  // A call to the floor being served is swallowed, even if it arrives in the clearing cycle.
  assign clr_mask  = ((state_q == ARRIVE) || (state_q == DOOR_WAIT)) ? floor_oh : '0;
  assign pending_d = (pending_q | call_req) & ~clr_mask;

  travel_timer #(
    .LIMIT (TRAVEL_CYC)
  ) u_travel (
    .clk_i (clk),
    .rst_i (r),
    .clr_i (state_q != MOVE),
    .en_i  (state_q == MOVE),
    .tc_o  (travel_tc)
  );

`ifdef DOOR_TIMEOUT_EN
  logic wdog_tc;
  logic fault_q, fault_d;

  travel_timer #(
    .LIMIT (DOOR_TMO_CYC)
  ) u_wdog (
    .clk_i (clk),
    .rst_i (r),
    .clr_i (state_q != DOOR_WAIT),
    .en_i  (state_q == DOOR_WAIT),
    .tc_o  (wdog_tc)
  );

  always_ff @(posedge clk or posedge r) begin
    if (r) fault_q <= 1'b0;
    else   fault_q <= fault_d;
  end

  assign door_fault = fault_q;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
`ifdef DOOR_TIMEOUT_EN
    fault_d = fault_q;
`endif
    arr     = 1'b0;
    moving  = 1'b0;
    dir_up  = (dir_q == DIR_UP);
    dir_dn  = (dir_q == DIR_DN);

    case (state_q)
      IDLE: begin
        if (pending_q == '0) begin
          dir_d = DIR_NONE;
        end else if ((pending_q & floor_oh) != '0) begin
          state_d = ARRIVE;
        end else begin
          dir_d   = choose_dir(|above_cur_v, |below_cur_v, dir_q);
          state_d = MOVE;
        end
      end
      MOVE: begin
        moving = 1'b1;
        if (travel_tc) begin
          floor_d = floor_nxt;
          if ((pending_q & nxt_oh) != '0) begin
            state_d = ARRIVE;
          end else if (!ahead_nxt) begin
            dir_d = choose_dir(|above_nxt_v, |below_nxt_v, dir_q);
          end
        end
      end
      ARRIVE: begin
        arr     = 1'b1;
        state_d = DOOR_WAIT;
      end
      DOOR_WAIT: begin
        // The door block still shows the previous close during our first waiting cycle.
        if (!dw_first_q && door_closed) begin
          state_d = IDLE;
        end
`ifdef DOOR_TIMEOUT_EN
        else if (wdog_tc) begin
          state_d = ARRIVE;
          fault_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q    <= IDLE;
      dir_q      <= DIR_NONE;
      floor_q    <= '0;
      pending_q  <= '0;
      dw_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      floor_q    <= floor_d;
      pending_q  <= pending_d;
      dw_first_q <= (state_q == ARRIVE);
    end
  end

  assign floor   = floor_q;
  assign pending = pending_q;

`ifndef SYNTHESIS
  a_params_ok : assert property (@(posedge clk) PARAMS_OK);

  a_no_overrun : assert property (@(posedge clk) disable iff (r)
    (state_q == MOVE && travel_tc) |->
      ((dir_q == DIR_UP && floor_q != FLOOR_W'(FLOORS - 1)) ||
       (dir_q == DIR_DN && floor_q != '0)));
`endif

endmodule
